// File: rtl/fetch_prefetch_pkg.sv
// fetch_pkg: shared types and default widths for the prefetching fetch unit.
//   fetch_state_e   IDLE / RUN fetch FSM state
//   DEF_PC_W        default program counter / ROM address width
//   DEF_INSTR_W     default instruction width
//   DEF_DEPTH       default prefetch queue depth (power of 2, >= 2)
// The queue entry struct depends on the user's widths, so it is declared in
// the module that owns those parameters.
package fetch_pkg;

  localparam int unsigned DEF_PC_W    = 16;
  localparam int unsigned DEF_INSTR_W = 9;
  localparam int unsigned DEF_DEPTH   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: ROM bus and decode handshake of the fetch unit.
//   rom_addr_o  fetch -> ROM     instruction address (current PC)
//   rom_data_i  ROM -> fetch     instruction at rom_addr_o, same cycle
//   instr_o     fetch -> decode  head-of-queue instruction
//   instr_pc_o  fetch -> decode  PC of instr_o
//   valid_o     fetch -> decode  instr_o / instr_pc_o valid
//   ready_i     decode -> fetch  decode accepts the head this cycle
// master = fetch unit side, slave = ROM/decode side.
interface fetch_prefetch_if #(
  parameter int unsigned PC_W    = fetch_pkg::DEF_PC_W,
  parameter int unsigned INSTR_W = fetch_pkg::DEF_INSTR_W
);

  logic [PC_W-1:0]    rom_addr_o;
  logic [INSTR_W-1:0] rom_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               valid_o;
  logic               ready_i;

  modport master (
    output rom_addr_o, instr_o, instr_pc_o, valid_o,
    input  rom_data_i, ready_i
  );

  modport slave (
    input  rom_addr_o, instr_o, instr_pc_o, valid_o,
    output rom_data_i, ready_i
  );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO used as the prefetch queue.
//   clk, rst_n_i   clock, synchronous active-low reset
//   flush_i        empty the queue this cycle (overrides push/pop)
//   push_i, data_i enqueue data_i
//   pop_i          dequeue the head (ignored when empty)
//   head_o         entry at the read pointer
//   full_o,empty_o occupancy flags
module fetch_fifo #(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (rst_n_i && !flush_i && do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC generator + DEPTH-entry prefetch queue.
//   clk              rising-edge clock
//   rst_n_i          synchronous active-low reset
//   start_i          (re)start at start_address_i, flushes the queue
//   start_address_i  start PC
//   branch_i         taken branch in RUN, flushes the queue
//   branchloc_i      branch target PC
//   halt_i           stop fetching (RUN -> IDLE), queue keeps draining
//   bus              ROM address/data and decode valid/ready handshake
//   running_o        FSM is in RUN
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [PC_W-1:0]      start_address_i,
  input  logic                 branch_i,
  input  logic [PC_W-1:0]      branchloc_i,
  input  logic                 halt_i,
  fetch_prefetch_if.master     bus,
  output logic                 running_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic flush, push, pop;
  logic full, empty;
  fetch_entry_t wr_entry, head;

  assign pop      = bus.valid_o && bus.ready_i;
  assign wr_entry = '{pc: pc_q, instr: bus.rom_data_i};

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    push    = 1'b0;
    if (start_i) begin
      state_d = RUN;
      pc_d    = start_address_i;
      flush   = 1'b1;
    end else if (state_q == RUN) begin
      if (branch_i) begin
        pc_d  = branchloc_i;
        flush = 1'b1;
      end else if (halt_i) begin
        state_d = IDLE;
      end else begin
        // A pop frees the slot this cycle, so a full queue still accepts.
        push = !full || pop;
        if (push) pc_d = pc_q + PC_W'(1);
      end
    end
  end

  fetch_fifo #(
    .W     (PC_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.rom_addr_o = pc_q;
  assign bus.valid_o    = !empty;
  // Head data is zeroed while empty so the reset/flush view is clean.
  assign bus.instr_o    = empty ? '0 : head.instr;
  assign bus.instr_pc_o = empty ? '0 : head.pc;
  assign running_o      = (state_q == RUN);

endmodule
